factorial_bcd: RTL

Downstream consumer of the factorial datapath. It watches the factorial `done` flag and captures `result` on the rising edge of `done`. It converts the captured binary value to packed BCD digits using a sequential double-dabble (shift/add-3), one bit per cycle. The BCD digits are held for the display/readout logic until acknowledged or superseded.

---
 rtl/factorial_pkg.sv | 15 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/factorial_bcd.sv | 101 ++++++++++
 3 files changed

// File: rtl/factorial_pkg.sv
// factorial_pkg: shared types and sizing helpers for the factorial BCD converter.
package factorial_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    // Decimal digits of 2^size-1 equal floor(size*log10(2))+1, since 2^size is never a power of ten.
    function automatic int bcd_digits(input int size);
        return (size * 30103) / 100000 + 1;
    endfunction

    function automatic int cnt_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble correction, adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/factorial_bcd.sv
// factorial_bcd: captures the factorial result on a done rising edge and converts it
// to packed BCD with a sequential double-dabble, one bit per cycle.
module factorial_bcd
    import factorial_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  done_in,
    input  logic [SIZE-1:0]       result_in,
    input  logic                  ack,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = cnt_width(SIZE);

    if (DIGITS < bcd_digits(SIZE)) begin : g_digits_check
        $error("factorial_bcd: DIGITS too small for SIZE");
    end

    state_t          state;
    logic            done_d;
    logic [SIZE-1:0] bin;
    logic [BW-1:0]   work;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   shifted;
    logic [CW-1:0]   cnt;
    logic            rise;

    assign rise    = done_in & ~done_d;
    assign shifted = {adj[BW-2:0], bin[SIZE-1]};

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (work[4*d +: 4]),
            .adjusted (adj[4*d +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done_d    <= 1'b0;
            bin       <= '0;
            work      <= '0;
            cnt       <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done_d <= done_in;
            case (state)
                IDLE: begin
                    if (rise) begin
                        bin   <= result_in;
                        work  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise)
                        overrun <= 1'b1;
                    work <= shifted;
                    bin  <= bin << 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(SIZE - 1)) begin
                        bcd_out   <= shifted;
                        bcd_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // A new result outranks the acknowledge: restart rather than idle.
                    if (rise) begin
                        bcd_valid <= 1'b0;
                        bin       <= result_in;
                        work      <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else if (ack) begin
                        bcd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
